// File: rtl/reshape_scheduler_pkg.sv
// Shared definitions for the reshape scheduler: field widths, FSM state
// encoding and a launch-time helper that spots an empty job.
package reshape_scheduler_pkg;

    localparam int WIDTH_FEATURE_SIZE    = 11;
    localparam int WIDTH_CHANNEL_NUM_REG = 10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_STREAM  = 3'd3,
        S_WR_REQ  = 3'd4,
        S_WR_WAIT = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // A job with any zero-sized dimension has nothing to stream.
    function automatic logic cfg_has_zero(
        input logic [WIDTH_FEATURE_SIZE-1:0]    row_in,
        input logic [WIDTH_CHANNEL_NUM_REG-1:0] ch_num,
        input logic [WIDTH_FEATURE_SIZE-1:0]    row_out
    );
        return (row_in == '0) || (ch_num == '0) || (row_out == '0);
    endfunction

endpackage

// File: rtl/reshape_beat_counter.sv
// Nested channel/column beat counter. Channel is the inner counter; column
// advances when channel wraps. Flags the last beat of a row and the transfer
// that completes a row.
module reshape_beat_counter
    import reshape_scheduler_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_i,
    input  logic                             en_i,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] ch_max_i,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    col_max_i,
    output logic [WIDTH_CHANNEL_NUM_REG-1:0] ch_cnt_o,
    output logic [WIDTH_FEATURE_SIZE-1:0]    col_cnt_o,
    output logic                             beat_last_o,
    output logic                             row_wrap_o
);

    logic [WIDTH_CHANNEL_NUM_REG-1:0] ch_cnt_q, ch_cnt_d;
    logic [WIDTH_FEATURE_SIZE-1:0]    col_cnt_q, col_cnt_d;
    logic                             ch_at_max;
    logic                             col_at_max;

    assign ch_at_max  = (ch_cnt_q == ch_max_i);
    assign col_at_max = (col_cnt_q == col_max_i);

    // Next-count logic: clear on launch, advance only on an accepted beat.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        ch_cnt_d  = ch_cnt_q;
        col_cnt_d = col_cnt_q;
        if (clr_i) begin
            ch_cnt_d  = '0;
            col_cnt_d = '0;
        end else if (en_i) begin
            if (ch_at_max) begin
                ch_cnt_d  = '0;
                col_cnt_d = col_at_max ? '0 : col_cnt_q + WIDTH_FEATURE_SIZE'(1);
            end else begin
                ch_cnt_d  = ch_cnt_q + WIDTH_CHANNEL_NUM_REG'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            ch_cnt_q  <= '0;
            col_cnt_q <= '0;
        end else begin
            ch_cnt_q  <= ch_cnt_d;
            col_cnt_q <= col_cnt_d;
        end
    end

    assign ch_cnt_o    = ch_cnt_q;
    assign col_cnt_o   = col_cnt_q;
    assign beat_last_o = ch_at_max && col_at_max;
    assign row_wrap_o  = en_i && ch_at_max && col_at_max;

endmodule

// File: rtl/reshape_scheduler.sv
// Reshape/concat sequencing controller. Latches the job on Start, then per
// output row: optional DDR read, Row_Num_In x Channel_RAM_Num streamed beats,
// optional DDR write. Pulses Reshape_Complete when all rows are done.
// Optional busy-cycle counter output Cycle_Cnt when RESHAPE_PERF_CNT_EN is defined.
module reshape_scheduler
    import reshape_scheduler_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Start,
    input  logic                             Read_DDR_REG,
    input  logic                             Write_DDR_REG,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_In_REG,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_RAM_Num_REG,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
    output logic                             Read_Req,
    input  logic                             Read_Done,
    output logic                             Write_Req,
    input  logic                             Write_Done,
    output logic                             Beat_Valid,
    input  logic                             Beat_Ready,
    output logic [WIDTH_CHANNEL_NUM_REG-1:0] Ch_Cnt,
    output logic [WIDTH_FEATURE_SIZE-1:0]    Col_Cnt,
    output logic [WIDTH_FEATURE_SIZE-1:0]    Row_Cnt,
    output logic                             Beat_Last,
    output logic                             Busy,
    output logic                             Reshape_Complete
`ifdef RESHAPE_PERF_CNT_EN
    ,
    output logic [31:0]                      Cycle_Cnt
`endif
);

    state_t                           state_q, state_d;
    logic                             rd_en_q, wr_en_q;
    logic [WIDTH_FEATURE_SIZE-1:0]    row_in_q, row_out_q;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] ch_num_q;
    logic [WIDTH_FEATURE_SIZE-1:0]    row_cnt_q, row_cnt_d;
    logic                             cfg_load;
    logic                             row_end;
    logic                             beat_en;
    logic                             beat_last;
    logic                             row_wrap;

    assign beat_en = (state_q == S_STREAM) && Beat_Ready;

    reshape_beat_counter u_beat_counter (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (cfg_load),
        .en_i        (beat_en),
        .ch_max_i    (ch_num_q - WIDTH_CHANNEL_NUM_REG'(1)),
        .col_max_i   (row_in_q - WIDTH_FEATURE_SIZE'(1)),
        .ch_cnt_o    (Ch_Cnt),
        .col_cnt_o   (Col_Cnt),
        .beat_last_o (beat_last),
        .row_wrap_o  (row_wrap)
    );

    // Next-state logic, including the shared end-of-row decision.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        cfg_load  = 1'b0;
        row_end   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    cfg_load  = 1'b1;
                    row_cnt_d = '0;
                    if (cfg_has_zero(Row_Num_In_REG, Channel_RAM_Num_REG, Row_Num_Out_REG))
                        state_d = S_DONE;
                    else
                        state_d = Read_DDR_REG ? S_RD_REQ : S_STREAM;
                end
            end
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: if (Read_Done) state_d = S_STREAM;
            S_STREAM: begin
                if (row_wrap) begin
                    if (wr_en_q) state_d = S_WR_REQ;
                    else         row_end = 1'b1;
                end
            end
            S_WR_REQ:  state_d = S_WR_WAIT;
            S_WR_WAIT: if (Write_Done) row_end = 1'b1;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (row_end) begin
            if (row_cnt_q == row_out_q - WIDTH_FEATURE_SIZE'(1)) begin
                state_d = S_DONE;
            end else begin
                row_cnt_d = row_cnt_q + WIDTH_FEATURE_SIZE'(1);
                state_d   = rd_en_q ? S_RD_REQ : S_STREAM;
            end
        end
    end

    // State and row counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Job configuration, captured only on an accepted Start.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: config flops are reset so a stray pre-launch read sees a defined zero job.
        if (rst) begin
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            row_in_q  <= '0;
            ch_num_q  <= '0;
            row_out_q <= '0;
        end else if (cfg_load) begin
            rd_en_q   <= Read_DDR_REG;
            wr_en_q   <= Write_DDR_REG;
            row_in_q  <= Row_Num_In_REG;
            ch_num_q  <= Channel_RAM_Num_REG;
            row_out_q <= Row_Num_Out_REG;
        end
    end

    assign Read_Req         = (state_q == S_RD_REQ);
    assign Write_Req        = (state_q == S_WR_REQ);
    assign Beat_Valid       = (state_q == S_STREAM);
    assign Beat_Last        = (state_q == S_STREAM) && beat_last;
    assign Busy             = (state_q != S_IDLE);
    assign Reshape_Complete = (state_q == S_DONE);
    assign Row_Cnt          = row_cnt_q;

`ifdef RESHAPE_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;

    // Busy-cycle counter: clears on launch, saturates, holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
        end else if (cfg_load) begin
            cycle_cnt_q <= '0;
        end else if (Busy && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign Cycle_Cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_reshape_scheduler.sv
// Self-checking bench for reshape_scheduler: table of whole jobs with
// hand-computed request/beat/busy counts, per-beat order checks, plus
// hand-written reset sequences.
module tb_reshape_scheduler;
    import reshape_scheduler_pkg::*;

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             Start = 1'b0;
    logic                             Read_DDR_REG = 1'b0;
    logic                             Write_DDR_REG = 1'b0;
    logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_In_REG = '0;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_RAM_Num_REG = '0;
    logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG = '0;
    logic                             Read_Req;
    logic                             Read_Done = 1'b0;
    logic                             Write_Req;
    logic                             Write_Done = 1'b0;
    logic                             Beat_Valid;
    logic                             Beat_Ready = 1'b0;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] Ch_Cnt;
    logic [WIDTH_FEATURE_SIZE-1:0]    Col_Cnt;
    logic [WIDTH_FEATURE_SIZE-1:0]    Row_Cnt;
    logic                             Beat_Last;
    logic                             Busy;
    logic                             Reshape_Complete;
`ifdef RESHAPE_PERF_CNT_EN
    logic [31:0]                      Cycle_Cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    reshape_scheduler dut (
        .clk                 (clk),
        .rst                 (rst),
        .Start               (Start),
        .Read_DDR_REG        (Read_DDR_REG),
        .Write_DDR_REG       (Write_DDR_REG),
        .Row_Num_In_REG      (Row_Num_In_REG),
        .Channel_RAM_Num_REG (Channel_RAM_Num_REG),
        .Row_Num_Out_REG     (Row_Num_Out_REG),
        .Read_Req            (Read_Req),
        .Read_Done           (Read_Done),
        .Write_Req           (Write_Req),
        .Write_Done          (Write_Done),
        .Beat_Valid          (Beat_Valid),
        .Beat_Ready          (Beat_Ready),
        .Ch_Cnt              (Ch_Cnt),
        .Col_Cnt             (Col_Cnt),
        .Row_Cnt             (Row_Cnt),
        .Beat_Last           (Beat_Last),
        .Busy                (Busy),
        .Reshape_Complete    (Reshape_Complete)
`ifdef RESHAPE_PERF_CNT_EN
        ,
        .Cycle_Cnt           (Cycle_Cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int rin;
        int ch;
        int rout;
        int rd;
        int wr;
        int ready_mode;   // 0: ready always, 1: ready on every other valid cycle
        int inj;          // busy-cycle index of an extra Start pulse, 0 = none
        int exp_rd;
        int exp_wr;
        int exp_beats;
        int exp_last;
        int exp_busy;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(Busy), 0);
        check({tag, "_valid"}, 32'(Beat_Valid), 0);
        check({tag, "_rdreq"}, 32'(Read_Req), 0);
        check({tag, "_wrreq"}, 32'(Write_Req), 0);
        check({tag, "_last"},  32'(Beat_Last), 0);
        check({tag, "_cmpl"},  32'(Reshape_Complete), 0);
        check({tag, "_cnts"},  32'({Ch_Cnt, Col_Cnt, Row_Cnt}), 0);
`ifdef RESHAPE_PERF_CNT_EN
        check({tag, "_cyc"},   Cycle_Cnt, 0);
`endif
    endtask

    // Launch one job, act as DMA (Done two cycles after each request) and
    // datapath sink, and compare against the vector's expected totals.
    task automatic run_job(input vec_t v, input int id);
        int  n_rd, n_wr, n_beats, n_last, n_busy, vcount, rd_t, wr_t, cyc;
        int  per_row, k;
        bit  done;
        n_rd = 0; n_wr = 0; n_beats = 0; n_last = 0; n_busy = 0;
        vcount = 0; rd_t = 0; wr_t = 0; cyc = 0; done = 1'b0;
        per_row = (v.rin * v.ch == 0) ? 1 : v.rin * v.ch;

        @(negedge clk);
        Row_Num_In_REG      = WIDTH_FEATURE_SIZE'(v.rin);
        Channel_RAM_Num_REG = WIDTH_CHANNEL_NUM_REG'(v.ch);
        Row_Num_Out_REG     = WIDTH_FEATURE_SIZE'(v.rout);
        Read_DDR_REG        = v.rd[0];
        Write_DDR_REG       = v.wr[0];
        Start               = 1'b1;
        @(negedge clk);
        Start = 1'b0;

        while (!done && cyc < 600) begin
            Start = (v.inj != 0) && (cyc == v.inj);
            if (Start) begin
                Row_Num_In_REG      = 11'd7;
                Channel_RAM_Num_REG = 10'd5;
                Row_Num_Out_REG     = 11'd4;
                Read_DDR_REG        = 1'b1;
                Write_DDR_REG       = 1'b1;
            end
            Read_Done  = 1'b0;
            Write_Done = 1'b0;
            if (rd_t > 0) begin rd_t--; if (rd_t == 0) Read_Done = 1'b1; end
            if (wr_t > 0) begin wr_t--; if (wr_t == 0) Write_Done = 1'b1; end
            Beat_Ready = (v.ready_mode == 0) || (vcount % 2 == 0);

            if (Busy) n_busy++;
            if (Read_Req) begin n_rd++; rd_t = 2; end
            if (Write_Req) begin n_wr++; wr_t = 2; end
            if (Beat_Valid) begin
                if (Beat_Ready) begin
                    k = n_beats % per_row;
                    check($sformatf("v%0d_b%0d_row", id, n_beats), 32'(Row_Cnt), 32'(n_beats / per_row));
                    check($sformatf("v%0d_b%0d_col", id, n_beats), 32'(Col_Cnt), 32'(k / v.ch));
                    check($sformatf("v%0d_b%0d_ch", id, n_beats), 32'(Ch_Cnt), 32'(k % v.ch));
                    check($sformatf("v%0d_b%0d_last", id, n_beats), 32'(Beat_Last),
                          32'(k == per_row - 1));
                    if (Beat_Last) n_last++;
                    n_beats++;
                end
                vcount++;
            end
            if (Reshape_Complete) done = 1'b1;
            cyc++;
            @(negedge clk);
        end
        Start = 1'b0; Read_Done = 1'b0; Write_Done = 1'b0; Beat_Ready = 1'b0;

        check($sformatf("v%0d_completed", id), 32'(done), 1);
        check($sformatf("v%0d_rd_reqs", id),   32'(n_rd), 32'(v.exp_rd));
        check($sformatf("v%0d_wr_reqs", id),   32'(n_wr), 32'(v.exp_wr));
        check($sformatf("v%0d_beats", id),     32'(n_beats), 32'(v.exp_beats));
        check($sformatf("v%0d_lasts", id),     32'(n_last), 32'(v.exp_last));
        check($sformatf("v%0d_busy_cyc", id),  32'(n_busy), 32'(v.exp_busy));
        check($sformatf("v%0d_busy_drop", id), 32'(Busy), 0);
        check($sformatf("v%0d_cmpl_pulse", id), 32'(Reshape_Complete), 0);
`ifdef RESHAPE_PERF_CNT_EN
        check($sformatf("v%0d_cycle_cnt", id), Cycle_Cnt, 32'(v.exp_busy));
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_cycle_hold", id), Cycle_Cnt, 32'(v.exp_busy));
`endif
    endtask

    initial begin
        //          rin ch rout rd wr rdy inj  rd wr beats last busy
        vecs[0] = '{2, 3, 2,   1, 1, 0,  0,   2, 2, 12,   2,   25};
        vecs[1] = '{2, 3, 2,   0, 0, 0,  0,   0, 0, 12,   2,   13};
        vecs[2] = '{2, 3, 2,   0, 0, 1,  0,   0, 0, 12,   2,   24};
        vecs[3] = '{2, 3, 0,   1, 1, 0,  0,   0, 0, 0,    0,   1};
        vecs[4] = '{1, 1, 3,   1, 0, 0,  0,   3, 0, 3,    3,   13};
        vecs[5] = '{4, 0, 2,   0, 1, 0,  0,   0, 0, 0,    0,   1};
        vecs[6] = '{2, 3, 1,   0, 0, 0,  2,   0, 0, 6,    1,   7};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i], i);
        end

        // Reset while waiting on a DMA read: outputs drop without a clock edge.
        @(negedge clk);
        Row_Num_In_REG = 11'd2; Channel_RAM_Num_REG = 10'd3; Row_Num_Out_REG = 11'd2;
        Read_DDR_REG = 1'b1; Write_DDR_REG = 1'b1;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("rst_seq_rdreq", 32'(Read_Req), 1);
        @(negedge clk);
        check("rst_seq_in_wait", 32'(Busy && !Read_Req && !Beat_Valid), 1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;

        run_job(vecs[0], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
